// File: rtl/mac4b_issue_ctrl.sv
// mac4b_issue_ctrl: CV-X-IF issue/commit/result sequencer for the MAC4B datapath.
// Accepted MAC4B instructions wait in a small in-order buffer until the core
// commits or kills them; committed heads run one at a time on the datapath.
module mac4b_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3,
  parameter int XLEN  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_W-1:0]     issue_id_i,
  input  logic [3*XLEN-1:0]   issue_rs_i,
  input  logic [2:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_W-1:0]     commit_id_i,
  input  logic                commit_kill_i,
  output logic                mac_req_o,
  input  logic                mac_gnt_i,
  output logic [3*XLEN-1:0]   mac_op_o,
  input  logic                mac_done_i,
  input  logic [XLEN-1:0]     mac_res_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_W-1:0]     result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o,
  output logic                busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, WAIT_COMMIT, EXEC, BUSY, WB} state_e;

  state_e state_q, state_d;

  // Payload storage and per-entry status flags.
  logic [ID_W-1:0]   id_mem [DEPTH];
  logic [4:0]        rd_mem [DEPTH];
  logic [3*XLEN-1:0] rs_mem [DEPTH];
  logic [DEPTH-1:0]  committed_q, killed_q;

  // Write, head and oldest-uncommitted pointers; occupancy and uncommitted counts.
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, cm_ptr_q;
  logic [CW-1:0] count_q, ucount_q;

  logic [ID_W-1:0] res_id_q;
  logic [4:0]      res_rd_q;
  logic [XLEN-1:0] res_data_q;

  // Set when a reset cancels an operation the datapath already took, so its
  // trailing done pulse is expected rather than a protocol error.
  logic drop_done_q;

  logic match, full, empty, push, pop, capture;
  logic cm_avail, commit_ok;
  logic [ID_W-1:0] cm_id;

  assign match = ((issue_instr_i & 32'h0600_707F) == 32'h0400_0033) && (&issue_rs_valid_i);
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign issue_ready_o     = issue_valid_i && (!match || !full);
  assign issue_accept_o    = issue_valid_i && match;
  assign issue_writeback_o = issue_accept_o;
  assign push              = issue_valid_i && match && !full;

  // With no uncommitted entry buffered, a commit can only target the entry
  // being written this same cycle, which lands at cm_ptr_q == wr_ptr_q.
  assign cm_avail  = (ucount_q != '0) || push;
  assign cm_id     = (ucount_q != '0) ? id_mem[cm_ptr_q] : issue_id_i;
  assign commit_ok = commit_valid_i && cm_avail && (commit_id_i == cm_id);

  assign result_valid_o = (state_q == WB);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;
  assign busy_o         = !empty || (state_q != IDLE);

  // Next-state and datapath request decode for the head entry.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    state_d   = state_q;
    pop       = 1'b0;
    capture   = 1'b0;
    mac_req_o = 1'b0;
    mac_op_o  = '0;
    case (state_q)
      IDLE:        if (!empty) state_d = WAIT_COMMIT;
      WAIT_COMMIT: begin
        if (killed_q[rd_ptr_q]) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else if (committed_q[rd_ptr_q]) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        mac_req_o = 1'b1;
        mac_op_o  = rs_mem[rd_ptr_q];
        if (mac_gnt_i) state_d = BUSY;
      end
      BUSY: begin
        if (mac_done_i) begin
          pop     = 1'b1;
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB:      if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload write on accept.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload arrays are not reset; occupancy is tracked by the
    // counters, so stale contents are never observed.
    if (push) begin
      id_mem[wr_ptr_q] <= issue_id_i;
      rd_mem[wr_ptr_q] <= issue_instr_i[11:7];
      rs_mem[wr_ptr_q] <= issue_rs_i;
    end
  end

  // Pointers, counts and commit/kill flags.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      count_q     <= '0;
      ucount_q    <= '0;
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q              <= wr_ptr_q + 1'b1;
        committed_q[wr_ptr_q] <= 1'b0;
        killed_q[wr_ptr_q]    <= 1'b0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Placed after the push clear so a same-cycle commit of the new entry wins.
      if (commit_ok) begin
        cm_ptr_q <= cm_ptr_q + 1'b1;
        if (commit_kill_i) killed_q[cm_ptr_q] <= 1'b1;
        else               committed_q[cm_ptr_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      case ({push, commit_ok})
        2'b10:   ucount_q <= ucount_q + 1'b1;
        2'b01:   ucount_q <= ucount_q - 1'b1;
        default: ucount_q <= ucount_q;
      endcase
    end
  end

  // FSM state, registered result fields and cancelled-operation tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      if ((state_q == BUSY) || ((state_q == EXEC) && mac_gnt_i)) drop_done_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (capture) begin
        res_id_q   <= id_mem[rd_ptr_q];
        res_rd_q   <= rd_mem[rd_ptr_q];
        res_data_q <= mac_res_i;
      end
      if (mac_done_i) drop_done_q <= 1'b0;
    end
  end

  // Protocol checks: in-order commits by ID, and done only while an op is in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (commit_valid_i) begin
        a_commit_order: assert (cm_avail && (commit_id_i == cm_id));
      end
      if (mac_done_i) begin
        a_done_in_busy: assert ((state_q == BUSY) || drop_done_q);
      end
    end
  end

endmodule

// File: tb/tb_mac4b_issue_ctrl.sv
// tb_mac4b_issue_ctrl: scoreboard bench; the bench also plays the MAC4B datapath.
module tb_mac4b_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int XLEN  = 32;
  localparam logic [31:0] MAC_BASE  = 32'h04C5_8033;
  localparam logic [31:0] ADD_INSTR = 32'h00B5_0533;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [31:0]       issue_instr_i;
  logic [ID_W-1:0]   issue_id_i;
  logic [3*XLEN-1:0] issue_rs_i;
  logic [2:0]        issue_rs_valid_i;
  logic              issue_accept_o;
  logic              issue_writeback_o;
  logic              commit_valid_i;
  logic [ID_W-1:0]   commit_id_i;
  logic              commit_kill_i;
  logic              mac_req_o;
  logic              mac_gnt_i;
  logic [3*XLEN-1:0] mac_op_o;
  logic              mac_done_i;
  logic [XLEN-1:0]   mac_res_i;
  logic              result_valid_o;
  logic              result_ready_i;
  logic [ID_W-1:0]   result_id_o;
  logic [4:0]        result_rd_o;
  logic [XLEN-1:0]   result_data_o;
  logic              result_we_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t pend_tab [8];
  exp_t mon_e;
  int req_count = 0;
  int done_count = 0;
  int lat = 1;
  int busy_cnt = 0;
  logic [XLEN-1:0]   pend_res;
  logic [3*XLEN-1:0] last_op;

  mac4b_issue_ctrl #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .mac_req_o(mac_req_o), .mac_gnt_i(mac_gnt_i), .mac_op_o(mac_op_o),
    .mac_done_i(mac_done_i), .mac_res_i(mac_res_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference MAC4B: sum of four unsigned byte products plus rs3.
  function automatic logic [XLEN-1:0] mac4b_model(input logic [XLEN-1:0] a, b, c);
    logic [XLEN-1:0] acc;
    acc = c;
    for (int i = 0; i < 4; i++) acc += XLEN'(a[8*i +: 8]) * XLEN'(b[8*i +: 8]);
    return acc;
  endfunction

  function automatic logic [31:0] mac_instr(input logic [4:0] rd);
    return MAC_BASE | {20'd0, rd, 7'd0};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Datapath model: grant on request, pulse done lat cycles later.
  always begin
    @(posedge clk_i);
    #1;
    mac_gnt_i  = 1'b0;
    mac_done_i = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        mac_done_i = 1'b1;
        mac_res_i  = pend_res;
        done_count++;
      end
    end else if (mac_req_o) begin
      mac_gnt_i = 1'b1;
      last_op   = mac_op_o;
      pend_res  = mac4b_model(mac_op_o[XLEN-1:0], mac_op_o[2*XLEN-1:XLEN], mac_op_o[3*XLEN-1:2*XLEN]);
      busy_cnt  = lat;
      req_count++;
    end
  end

  // Result monitor: every completed result handshake pops the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(result_id_o), 64'hFFFF);
      end else begin
        mon_e = sb.pop_front();
        check("result_id", 64'(result_id_o), 64'(mon_e.id));
        check("result_rd", 64'(result_rd_o), 64'(mon_e.rd));
        check("result_data", 64'(result_data_o), 64'(mon_e.data));
        check("result_we", 64'(result_we_o), 64'd1);
      end
    end
  end

  task automatic do_issue(input logic [31:0] instr, input logic [ID_W-1:0] id,
                          input logic [XLEN-1:0] rs1, rs2, rs3,
                          input logic [2:0] rsv, input bit exp_acc);
    int n;
    n = 0;
    issue_valid_i    = 1'b1;
    issue_instr_i    = instr;
    issue_id_i       = id;
    issue_rs_i       = {rs3, rs2, rs1};
    issue_rs_valid_i = rsv;
    #1;
    while (!issue_ready_o && n < 200) begin
      step();
      #1;
      n++;
    end
    check("issue_ready", 64'(issue_ready_o), 64'd1);
    check("issue_accept", 64'(issue_accept_o), 64'(exp_acc));
    check("issue_writeback", 64'(issue_writeback_o), 64'(exp_acc));
    if (exp_acc) pend_tab[id] = {id, instr[11:7], mac4b_model(rs1, rs2, rs3)};
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic do_commit(input logic [ID_W-1:0] id, input bit kill, input bit expect_res);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    if (expect_res) sb.push_back(pend_tab[id]);
    step();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 500) begin
      step();
      n++;
    end
    check(tag, 64'(sb.size() == 0 && !busy_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, n;
    bit saw;
    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
    issue_rs_i = '0; issue_rs_valid_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    mac_gnt_i = 1'b0; mac_done_i = 1'b0; mac_res_i = '0;
    result_ready_i = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_issue_ready", 64'(issue_ready_o), 64'd0);
    check("rst_issue_accept", 64'(issue_accept_o), 64'd0);
    check("rst_mac_req", 64'(mac_req_o), 64'd0);
    check("rst_mac_op", 64'(mac_op_o), 64'd0);
    check("rst_result_valid", 64'(result_valid_o), 64'd0);
    check("rst_result_fields", 64'({result_id_o, result_rd_o, result_data_o, result_we_o}), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    step();

    // Basic mac4b a0,a1,a2
    r0 = req_count;
    do_issue(32'h04C5_8533, 3'd2, 32'h0102_0304, 32'h0101_0101, 32'd10, 3'b111, 1'b1);
    do_commit(3'd2, 1'b0, 1'b1);
    wait_drain("t1_drain");
    check("t1_op", 64'(last_op == {32'd10, 32'h0101_0101, 32'h0102_0304}), 64'd1);
    check("t1_reqs", 64'(req_count - r0), 64'd1);

    // Non-matching instructions are acknowledged but never buffered
    do_issue(ADD_INSTR, 3'd1, 32'd1, 32'd2, 32'd3, 3'b111, 1'b0);
    check("t2_add_busy", 64'(busy_o), 64'd0);
    do_issue(mac_instr(5'd3), 3'd1, 32'd1, 32'd2, 32'd3, 3'b011, 1'b0);
    check("t2_rsv_busy", 64'(busy_o), 64'd0);

    // Fill the buffer, stall the fifth issue until the first op completes
    r0 = req_count;
    for (int i = 0; i < 4; i++)
      do_issue(mac_instr(5'(i + 1)), 3'(i), $urandom, $urandom, $urandom, 3'b111, 1'b1);
    d0 = done_count;
    issue_valid_i = 1'b1; issue_instr_i = mac_instr(5'd9); issue_id_i = 3'd4;
    issue_rs_i = {32'd7, 32'h0505_0505, 32'h0303_0303}; issue_rs_valid_i = 3'b111;
    #1;
    check("t3_full_stall", 64'(issue_ready_o), 64'd0);
    repeat (3) step();
    check("t3_still_stalled", 64'(issue_ready_o), 64'd0);
    do_commit(3'd0, 1'b0, 1'b1);
    n = 0;
    #1;
    while (!issue_ready_o && n < 100) begin
      step();
      #1;
      n++;
    end
    check("t3_fifth_ready", 64'(issue_ready_o), 64'd1);
    check("t3_fifth_accept", 64'(issue_accept_o), 64'd1);
    check("t3_after_pop", 64'(done_count > d0), 64'd1);
    pend_tab[4] = {3'd4, 5'd9, mac4b_model(32'h0303_0303, 32'h0505_0505, 32'd7)};
    step();
    issue_valid_i = 1'b0;
    for (int i = 1; i < 5; i++) do_commit(3'(i), 1'b0, 1'b1);
    wait_drain("t3_drain");
    check("t3_reqs", 64'(req_count - r0), 64'd5);

    // Commit / kill / commit
    r0 = req_count;
    for (int i = 1; i < 4; i++)
      do_issue(mac_instr(5'(i + 20)), 3'(i), $urandom, $urandom, $urandom, 3'b111, 1'b1);
    do_commit(3'd1, 1'b0, 1'b1);
    do_commit(3'd2, 1'b1, 1'b0);
    do_commit(3'd3, 1'b0, 1'b1);
    wait_drain("t4_drain");
    check("t4_reqs", 64'(req_count - r0), 64'd2);

    // Result back-pressure holds WB stable
    r0 = req_count;
    result_ready_i = 1'b0;
    do_issue(mac_instr(5'd30), 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1);
    do_issue(mac_instr(5'd31), 3'd7, 32'h0000_0102, 32'h0000_0304, 32'd0, 3'b111, 1'b1);
    do_commit(3'd6, 1'b0, 1'b1);
    do_commit(3'd7, 1'b0, 1'b1);
    n = 0;
    while (!result_valid_o && n < 100) begin
      step();
      n++;
    end
    check("t5_valid", 64'(result_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_hold_valid", 64'(result_valid_o), 64'd1);
      check("t5_hold_fields", 64'({result_id_o, result_rd_o, result_data_o}),
            64'({sb[0].id, sb[0].rd, sb[0].data}));
      check("t5_no_second_req", 64'(req_count - r0), 64'd1);
    end
    result_ready_i = 1'b1;
    wait_drain("t5_drain");
    check("t5_reqs", 64'(req_count - r0), 64'd2);

    // Issue and commit of the same ID in the same cycle
    r0 = req_count;
    issue_valid_i = 1'b1; issue_instr_i = mac_instr(5'd17); issue_id_i = 3'd5;
    issue_rs_i = {32'd100, 32'h0202_0202, 32'h0404_0404}; issue_rs_valid_i = 3'b111;
    commit_valid_i = 1'b1; commit_id_i = 3'd5; commit_kill_i = 1'b0;
    sb.push_back({3'd5, 5'd17, mac4b_model(32'h0404_0404, 32'h0202_0202, 32'd100)});
    #1;
    check("t6_ready", 64'(issue_ready_o), 64'd1);
    step();
    issue_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    wait_drain("t6_drain");
    check("t6_reqs", 64'(req_count - r0), 64'd1);

    // Reset during BUSY, late done is dropped
    lat = 6;
    r0 = req_count;
    do_issue(mac_instr(5'd12), 3'd3, 32'd5, 32'd6, 32'd7, 3'b111, 1'b1);
    do_commit(3'd3, 1'b0, 1'b0);
    n = 0;
    while (req_count == r0 && n < 100) begin
      step();
      n++;
    end
    check("t7_req_seen", 64'(req_count - r0), 64'd1);
    step();
    d0 = done_count;
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    check("t7_busy_after_rst", 64'(busy_o), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (result_valid_o) saw = 1'b1;
    end
    check("t7_no_result", 64'(saw), 64'd0);
    check("t7_late_done", 64'(done_count - d0), 64'd1);
    check("t7_busy_end", 64'(busy_o), 64'd0);
    lat = 1;

    // Recovery after reset
    do_issue(mac_instr(5'd1), 3'd0, 32'h1111_1111, 32'h0202_0202, 32'd9, 3'b111, 1'b1);
    do_commit(3'd0, 1'b0, 1'b1);
    wait_drain("t8_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
